// File: rtl/wb_common_pkg.sv
// Shared Wishbone B3 definitions: cycle/burst type codes, request payload and
// the registered-feedback burst address generator reused by arbiter/resize blocks.
package wb_common_pkg;

    localparam int unsigned WB_AW = 32;
    localparam int unsigned WB_DW = 32;
    localparam int unsigned WB_SW = 4;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } wb_resp_state_e;

    typedef struct packed {
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
        logic [WB_SW-1:0] sel;
        logic             we;
        logic [2:0]       cti;
        logic [1:0]       bte;
    } wb_req_t;

    // Address of the beat following adr; wrap bursts only step the in-block word bits.
    function automatic logic [WB_AW-1:0] wb_next_adr(input logic [WB_AW-1:0] adr,
                                                     input logic [2:0]       cti,
                                                     input logic [1:0]       bte);
        logic [WB_AW-1:0] inc;
        logic [WB_AW-1:0] wrap_mask;
        inc = adr + WB_AW'(4);
        case (bte)
            BTE_WRAP4:  wrap_mask = WB_AW'(32'h0000_000C);
            BTE_WRAP8:  wrap_mask = WB_AW'(32'h0000_001C);
            BTE_WRAP16: wrap_mask = WB_AW'(32'h0000_003C);
            default:    wrap_mask = '1;
        endcase
        if (cti == CTI_INCR) begin
            wb_next_adr = (adr & ~wrap_mask) | (inc & wrap_mask);
        end else begin
            wb_next_adr = adr;
        end
    endfunction

endpackage

// File: rtl/wb_ram_mem.sv
// 1R1W synchronous byte-enable RAM, 32-bit words, registered read port
// cleared by reset.
module wb_ram_mem #(
    parameter int unsigned MEM_WORDS = 2048,
    parameter int unsigned AW        = $clog2(MEM_WORDS),
    parameter string       INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rd_adr,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_adr,
    input  logic [3:0]    wr_sel,
    input  logic [31:0]   wr_data
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin : p_write
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_sel[b]) begin
                    mem[wr_adr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_read
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_adr];
        end
    end

endmodule

// File: rtl/wb_ram_responder.sv
// Wishbone B3 SRAM responder: classic cycles and registered-feedback bursts at one
// beat per cycle, byte-lane writes, err on addresses outside the populated window.
module wb_ram_responder
    import wb_common_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 2048,
    parameter int unsigned WIN_BITS  = 23,
    parameter string       INIT_FILE = ""
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic [WB_AW-1:0] wb_adr_i,
    input  logic [WB_DW-1:0] wb_dat_i,
    input  logic [WB_SW-1:0] wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic [2:0]       wb_cti_i,
    input  logic [1:0]       wb_bte_i,
    output logic [WB_DW-1:0] wb_dat_o,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    output logic             wb_rty_o
);

    localparam int unsigned AW_MEM = $clog2(MEM_WORDS);

    wb_req_t          req;
    wb_resp_state_e   state_q, state_d;
    logic             ack_r, ack_d;
    logic             err_r, err_d;
    logic             valid, last, beat_adv;
    logic [WB_AW-1:0] na;
    logic             oor, wr_oor, wr_en;
    logic             unused_na;

    assign req = {wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cti_i, wb_bte_i};

    // Anything other than const/incr burst codes is handled as a classic cycle.
    assign valid    = wb_cyc_i & wb_stb_i;
    assign last     = ~((req.cti == CTI_CONST) | (req.cti == CTI_INCR));
    assign wb_ack_o = ack_r & valid;
    assign wb_err_o = err_r & valid;
    assign wb_rty_o = 1'b0;

    // An acked non-final beat is a burst beat even from IDLE, so lookahead starts at once.
    assign beat_adv  = wb_ack_o & ~last;
    assign na        = beat_adv ? wb_next_adr(req.adr, req.cti, req.bte) : req.adr;
    assign oor       = |na[WIN_BITS-1:AW_MEM+2];
    assign wr_oor    = |req.adr[WIN_BITS-1:AW_MEM+2];
    assign wr_en     = wb_ack_o & req.we & ~wr_oor;
    assign unused_na = ^{na[WB_AW-1:WIN_BITS], na[1:0]};

    always_comb begin : p_next
        state_d = state_q;
        ack_d   = valid & ~oor & ~(wb_ack_o & last) & ~wb_err_o;
        err_d   = valid & oor & ~wb_err_o & ~(wb_ack_o & last);
        case (state_q)
            ST_IDLE: begin
                if (beat_adv) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (~valid | wb_err_o | (wb_ack_o & last)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin : p_state
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_r   <= ack_d;
            err_r   <= err_d;
        end
    end

    wb_ram_mem #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW_MEM),
        .INIT_FILE (INIT_FILE)
    ) u_mem (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n_i),
        .rd_adr  (na[AW_MEM+1:2]),
        .rd_data (wb_dat_o),
        .wr_en   (wr_en),
        .wr_adr  (req.adr[AW_MEM+1:2]),
        .wr_sel  (req.sel),
        .wr_data (req.dat)
    );

endmodule

// File: tb/tb_wb_ram_responder.sv
// Bench for wb_ram_responder: bus-master tasks drive classic and burst cycles and
// compare against a word-array memory model and the expected beat timing.
module tb_wb_ram_responder;

    localparam int unsigned MEM_WORDS = 2048;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic        wb_ack_o, wb_err_o, wb_rty_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] ref_mem [MEM_WORDS];

    always #5 clk = ~clk;

    wb_ram_responder dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_sel_i   (wb_sel_i),
        .wb_we_i    (wb_we_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_cti_i   (wb_cti_i),
        .wb_bte_i   (wb_bte_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .wb_rty_o   (wb_rty_o)
    );

    function automatic int widx(input logic [31:0] a);
        return int'(a[12:2]);
    endfunction

    // Byte address of beat i: linear steps by 4, wrap stays in an nw-word aligned block.
    function automatic logic [31:0] burst_adr(input logic [31:0] start, input logic [1:0] b, input int i);
        int unsigned nw, base, off;
        if (b == 2'b00) return start + 32'(4 * i);
        nw   = 32'd2 << b;
        base = (start / (nw * 4)) * (nw * 4);
        off  = (start - base) / 4;
        return 32'(base + ((off + 32'(i)) % nw) * 4);
    endfunction

    task automatic bus_idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
            wb_cti_i = 3'b000; wb_bte_i = 2'b00;
        end
    endtask

    // One classic cycle, held one extra cycle after the response to observe ack/err dropping.
    task automatic classic_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                                input logic [3:0] s, output logic [31:0] rd, output int waits,
                                output bit got_ack, output bit got_err, output bit ack2, output bit err2);
        waits = 0; got_ack = 0; got_err = 0; rd = '0;
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = a; wb_we_i = w;
        wb_dat_i = d; wb_sel_i = s; wb_cti_i = 3'b000; wb_bte_i = 2'b00;
        forever begin
            @(negedge clk);
            if (wb_ack_o || wb_err_o || waits == 8) break;
            waits++;
            @(posedge clk); #1;
        end
        got_ack = wb_ack_o; got_err = wb_err_o; rd = wb_dat_o;
        @(posedge clk); #1;
        @(negedge clk);
        ack2 = wb_ack_o; err2 = wb_err_o;
        bus_idle(2);
        if (got_ack && w && !got_err) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Registered-feedback incrementing burst with optional stb gap, expected err beat, or reset beat.
    task automatic do_burst(input string name, input logic [31:0] start, input logic [1:0] b,
                            input int nbeats, input logic w, input int gap_after, input int gap_len,
                            input int err_beat, input int rst_beat, output int acks);
        logic [31:0] a, d;
        int          waits, exp_wait;
        bit          ended;
        acks = 0; ended = 0;
        for (int i = 0; i < nbeats && !ended; i++) begin
            a = burst_adr(start, b, i);
            d = $urandom;
            @(posedge clk); #1;
            wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = a; wb_we_i = w; wb_dat_i = d;
            wb_sel_i = 4'hF; wb_cti_i = (i == nbeats - 1) ? 3'b111 : 3'b010; wb_bte_i = b;
            if (i == rst_beat) begin
                #2 rst_n = 1'b0;
                #1;
                n_checks++;
                if ({wb_ack_o, wb_err_o, wb_dat_o} !== 34'b0) begin
                    n_fail++;
                    $display("FAIL %s async_reset: ack=%b err=%b dat=%h, required all zero", name, wb_ack_o, wb_err_o, wb_dat_o);
                end
                @(posedge clk); #1;
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                ended = 1;
            end else begin
                exp_wait = (i == 0 || (gap_len > 0 && i == gap_after + 1)) ? 1 : 0;
                waits = 0;
                forever begin
                    @(negedge clk);
                    if (wb_ack_o || wb_err_o || waits == 8) break;
                    waits++;
                    @(posedge clk); #1;
                end
                n_checks++;
                if (i == err_beat) begin
                    if (!(wb_err_o === 1'b1 && wb_ack_o === 1'b0 && waits == 0)) begin
                        n_fail++;
                        $display("FAIL %s err_beat%0d: ack=%b err=%b waits=%0d, required err=1 ack=0 waits=0", name, i, wb_ack_o, wb_err_o, waits);
                    end
                    ended = 1;
                end else if (wb_ack_o !== 1'b1 || wb_err_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s beat%0d_ack: ack=%b err=%b, required ack=1 err=0", name, i, wb_ack_o, wb_err_o);
                    ended = 1;
                end else begin
                    acks++;
                    n_checks++;
                    if (waits != exp_wait) begin
                        n_fail++;
                        $display("FAIL %s beat%0d_latency: waits=%0d, required %0d", name, i, waits, exp_wait);
                    end
                    if (!w) begin
                        n_checks++;
                        if (wb_dat_o !== ref_mem[widx(a)]) begin
                            n_fail++;
                            $display("FAIL %s beat%0d_data @%h: got %h, required %h", name, i, a, wb_dat_o, ref_mem[widx(a)]);
                        end
                    end else begin
                        ref_mem[widx(a)] = d;
                    end
                    if (gap_len > 0 && i == gap_after) begin
                        for (int g = 0; g < gap_len; g++) begin
                            @(posedge clk); #1;
                            wb_stb_i = 1'b0;
                            @(negedge clk);
                            n_checks++;
                            if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin
                                n_fail++;
                                $display("FAIL %s gap%0d: ack=%b err=%b, required 0", name, g, wb_ack_o, wb_err_o);
                            end
                        end
                    end
                end
            end
        end
        if (!ended) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++;
            if (wb_ack_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s ack_after_last: ack=%b, required 0", name, wb_ack_o);
            end
        end
        bus_idle(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        wb_adr_i = 32'h10; wb_dat_i = '0; wb_sel_i = 4'hF; wb_we_i = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_cti_i = 3'b000; wb_bte_i = 2'b00;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({wb_ack_o, wb_err_o, wb_rty_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: ack/err/rty=%b, required 000", {wb_ack_o, wb_err_o, wb_rty_o});
        end
        n_checks++;
        if (wb_dat_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dat: got %h, required 00000000", wb_dat_o);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        rst_n = 1'b1;
        bus_idle(2);
    endtask

    task automatic test_classic();
        logic [31:0] rd; int waits; bit ack, err, ack2, err2;
        classic_xfer(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, rd, waits, ack, err, ack2, err2);
        n_checks++;
        if (!(ack && !err && waits == 1 && !ack2)) begin
            n_fail++;
            $display("FAIL classic_write: ack=%b err=%b waits=%0d ack_next=%b, required 1 0 1 0", ack, err, waits, ack2);
        end
        classic_xfer(32'h10, 1'b0, 32'h0, 4'hF, rd, waits, ack, err, ack2, err2);
        n_checks++;
        if (!(ack && waits == 1 && !ack2)) begin
            n_fail++;
            $display("FAIL classic_read_timing: ack=%b waits=%0d ack_next=%b, required 1 1 0", ack, waits, ack2);
        end
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL classic_read_data: got %h, required deadbeef", rd);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; int waits; bit ack, err, ack2, err2;
        classic_xfer(32'h20, 1'b1, 32'h11223344, 4'hF, rd, waits, ack, err, ack2, err2);
        classic_xfer(32'h20, 1'b1, 32'h000000AA, 4'b0001, rd, waits, ack, err, ack2, err2);
        classic_xfer(32'h20, 1'b0, 32'hFFFFFFFF, 4'b0000, rd, waits, ack, err, ack2, err2);
        n_checks++;
        if (rd !== 32'h112233AA) begin
            n_fail++;
            $display("FAIL byte_lanes: got %h, required 112233aa", rd);
        end
    endtask

    task automatic test_wrap4();
        logic [31:0] rd; int waits, acks; bit ack, err, ack2, err2;
        for (int k = 0; k < 4; k++)
            classic_xfer(32'h10 + 32'(4 * k), 1'b1, $urandom, 4'hF, rd, waits, ack, err, ack2, err2);
        do_burst("wrap4_1c", 32'h1C, 2'b01, 4, 1'b0, -1, 0, -1, -1, acks);
        n_checks++;
        if (acks != 4) begin
            n_fail++;
            $display("FAIL wrap4_acks: got %0d, required 4", acks);
        end
    endtask

    task automatic test_linear_gap();
        logic [31:0] rd; int waits, acks; bit ack, err, ack2, err2;
        do_burst("lin_gap", 32'h100, 2'b00, 8, 1'b1, 2, 2, -1, -1, acks);
        n_checks++;
        if (acks != 8) begin
            n_fail++;
            $display("FAIL lin_gap_acks: got %0d, required 8", acks);
        end
        for (int k = 0; k < 8; k++) begin
            classic_xfer(32'h100 + 32'(4 * k), 1'b0, 32'h0, 4'hF, rd, waits, ack, err, ack2, err2);
            n_checks++;
            if (!ack || rd !== ref_mem[64 + k]) begin
                n_fail++;
                $display("FAIL lin_gap_readback%0d: ack=%b got %h, required %h", k, ack, rd, ref_mem[64 + k]);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; int waits, acks; bit ack, err, ack2, err2;
        classic_xfer(32'h2000, 1'b0, 32'h0, 4'hF, rd, waits, ack, err, ack2, err2);
        n_checks++;
        if (!(err && !ack && waits == 1 && !err2 && !ack2)) begin
            n_fail++;
            $display("FAIL oor_classic: err=%b ack=%b waits=%0d err_next=%b ack_next=%b, required 1 0 1 0 0", err, ack, waits, err2, ack2);
        end
        do_burst("oor_burst", 32'h1FF8, 2'b00, 4, 1'b1, -1, 0, 2, -1, acks);
        n_checks++;
        if (acks != 2) begin
            n_fail++;
            $display("FAIL oor_burst_acks: got %0d, required 2", acks);
        end
        classic_xfer(32'h1FFC, 1'b0, 32'h0, 4'hF, rd, waits, ack, err, ack2, err2);
        n_checks++;
        if (!(ack && waits == 1 && rd === ref_mem[widx(32'h1FFC)])) begin
            n_fail++;
            $display("FAIL oor_after_idle: ack=%b waits=%0d got %h, required ack 1 waits 1 data %h", ack, waits, rd, ref_mem[widx(32'h1FFC)]);
        end
        classic_xfer(32'h0080_0010, 1'b0, 32'h0, 4'hF, rd, waits, ack, err, ack2, err2);
        n_checks++;
        if (!(ack && !err && rd === ref_mem[4])) begin
            n_fail++;
            $display("FAIL window_alias: ack=%b err=%b got %h, required ack 1 data %h", ack, err, rd, ref_mem[4]);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] rd; int waits, acks; bit ack, err, ack2, err2;
        for (int k = 0; k < 8; k++)
            classic_xfer(32'h200 + 32'(4 * k), 1'b1, $urandom, 4'hF, rd, waits, ack, err, ack2, err2);
        do_burst("rst_burst", 32'h200, 2'b00, 8, 1'b1, -1, 0, -1, 2, acks);
        n_checks++;
        if (acks != 2) begin
            n_fail++;
            $display("FAIL rst_burst_acks: got %0d, required 2", acks);
        end
        for (int k = 0; k < 8; k++) begin
            classic_xfer(32'h200 + 32'(4 * k), 1'b0, 32'h0, 4'hF, rd, waits, ack, err, ack2, err2);
            n_checks++;
            if (!(ack && waits == 1 && rd === ref_mem[128 + k])) begin
                n_fail++;
                $display("FAIL rst_readback%0d: ack=%b waits=%0d got %h, required %h", k, ack, waits, rd, ref_mem[128 + k]);
            end
        end
    endtask

    task automatic test_random_classic();
        logic [31:0] rd, a; int waits; bit ack, err, ack2, err2;
        int unsigned idx;
        for (int it = 0; it < 12; it++) begin
            idx = $urandom_range(0, MEM_WORDS - 1);
            a   = ($urandom & 32'hFF80_0000) | 32'(idx << 2);
            classic_xfer(a, 1'b1, $urandom, 4'hF, rd, waits, ack, err, ack2, err2);
            classic_xfer(a, 1'b1, $urandom, 4'($urandom_range(1, 15)), rd, waits, ack, err, ack2, err2);
            classic_xfer(a, 1'b0, 32'h0, 4'($urandom), rd, waits, ack, err, ack2, err2);
            n_checks++;
            if (!(ack && !err && rd === ref_mem[idx])) begin
                n_fail++;
                $display("FAIL random_classic%0d @%h: ack=%b err=%b got %h, required %h", it, a, ack, err, rd, ref_mem[idx]);
            end
        end
    endtask

    task automatic test_wrap_random();
        logic [31:0] base, start; int acks, nbeats;
        for (int b = 1; b < 4; b++) begin
            base = 32'($urandom_range(0, 127) * 64);
            do_burst("wrap_fill", base, 2'b00, 16, 1'b1, -1, 0, -1, -1, acks);
            start  = base + 32'($urandom_range(0, 15) * 4);
            nbeats = (2 << b) + 3;
            do_burst("wrap_rand", start, 2'(b), nbeats, 1'b0, -1, 0, -1, -1, acks);
            n_checks++;
            if (acks != nbeats) begin
                n_fail++;
                $display("FAIL wrap_rand_bte%0d_acks: got %0d, required %0d", b, acks, nbeats);
            end
        end
    endtask

    initial begin
        test_reset();
        test_classic();
        test_byte_lanes();
        test_wrap4();
        test_linear_gap();
        test_out_of_range();
        test_reset_mid_burst();
        test_random_classic();
        test_wrap_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
